// File: rtl/fnd_pkg.sv
// Shared segment constants and the nibble-to-segment encoder for the FND
// scan controller. Segment vectors are active-high, ordered {g,f,e,d,c,b,a}.
package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Codes 10-15 render as letters only when hex_en is set, otherwise blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] nibble,
                                            input logic       hex_en);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = hex_en ? SEG_A : SEG_BLANK;
      4'hB:    seg = hex_en ? SEG_B : SEG_BLANK;
      4'hC:    seg = hex_en ? SEG_C : SEG_BLANK;
      4'hD:    seg = hex_en ? SEG_D : SEG_BLANK;
      4'hE:    seg = hex_en ? SEG_E : SEG_BLANK;
      default: seg = hex_en ? SEG_F : SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational nibble-to-segment decoder with a blank override.
// Ports:
//   i_nibble  4-bit digit code
//   i_blank   1 forces all segments off (leading-zero suppression)
//   o_seg     active-high {g,f,e,d,c,b,a}
module fnd_seg_decoder
  import fnd_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  localparam logic L_HEX = (HEX_EN != 0);

  assign o_seg = i_blank ? SEG_BLANK : seg_encode(i_nibble, L_HEX);

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed N-digit 7-segment display driver.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_En            0 blanks the display and parks the scan on digit 0
//   i_value         packed nibbles, [3:0] = digit 0 (rightmost)
//   i_dp            decimal point per digit
//   i_blank_lz      leading-zero suppression enable
//   o_digit         one-hot digit select (polarity per SEL_ACTIVE_LOW)
//   o_fnd           {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
//   o_frame         one-cycle pulse on the first digit-0 cycle after a wrap
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_COUNT      = 100000,
  parameter int HEX_EN         = 1,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_En,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
  output logic [NUM_DIGITS-1:0]   o_digit,
  output logic [7:0]              o_fnd,
  output logic                    o_frame
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

  // "Off" patterns; XOR with these applies the output polarity.
  localparam logic [NUM_DIGITS-1:0] L_SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            L_SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic                    r_wrap;
  logic [NUM_DIGITS-1:0]   r_digit;
  logic [7:0]              r_fnd;
  logic                    r_frame;

  logic                  w_tick;
  logic                  w_last;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_blank_vec;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;

  assign w_tick   = (r_presc == PRE_W'(DIV_COUNT - 1));
  assign w_last   = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_onehot = NUM_DIGITS'(1) << r_idx;
  assign w_nibble = r_sh_value[4*r_idx +: 4];

  // Walk from the most significant digit down; a digit is a leading zero
  // while it and everything above it is zero. Digit 0 always shows.
  always_comb begin
    logic run;
    run         = 1'b1;
    w_blank_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run            = run & (r_sh_value[4*k +: 4] == 4'h0);
      w_blank_vec[k] = run & i_blank_lz & (k != 0);
    end
  end

  fnd_seg_decoder #(
    .HEX_EN (HEX_EN)
  ) u_seg_decoder (
    .i_nibble (w_nibble),
    .i_blank  (w_blank_vec[r_idx]),
    .o_seg    (w_seg)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_sh_value <= '0;
      r_sh_dp    <= '0;
      r_wrap     <= 1'b0;
      r_digit    <= L_SEL_OFF;
      r_fnd      <= L_SEG_OFF;
      r_frame    <= 1'b0;
    end else if (!i_En) begin
      // Shadow tracks the inputs so re-enable shows current data at once.
      r_presc    <= '0;
      r_idx      <= '0;
      r_sh_value <= i_value;
      r_sh_dp    <= i_dp;
      r_wrap     <= 1'b0;
      r_digit    <= L_SEL_OFF;
      r_fnd      <= L_SEG_OFF;
      r_frame    <= 1'b0;
    end else begin
      r_digit <= w_onehot ^ L_SEL_OFF;
      r_fnd   <= {r_sh_dp[r_idx], w_seg} ^ L_SEG_OFF;
      // Wrap is seen one cycle before digit 0 reaches the outputs, so the
      // frame pulse is delayed once more to line up with it.
      r_wrap  <= w_tick & w_last;
      r_frame <= r_wrap;
      if (w_tick) begin
        r_presc <= '0;
        if (w_last) begin
          r_idx      <= '0;
          r_sh_value <= i_value;
          r_sh_dp    <= i_dp;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign o_digit = r_digit;
  assign o_fnd   = r_fnd;
  assign o_frame = r_frame;

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Parametrised time-multiplexed FND (7-segment) display driver, the successor to the fixed 4-digit combinational digit-select decoder. It takes a packed N-digit hex/BCD value and per-digit decimal points, then scans the digits with a programmable refresh prescaler. It decodes each nibble to segments, optionally blanks leading zeros, and drives one-hot digit-select lines with selectable polarity. It sits between the counter/datapath logic and the board's common-anode/cathode display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DIV_COUNT, 100000, clock cycles each digit stays lit (>=1; 1 = advance every cycle)
HEX_EN, 1, 1: codes 10-15 shown as A,b,C,d,E,F; 0: codes 10-15 shown as blank
SEL_ACTIVE_LOW, 1, 1: the selected digit line is driven 0
SEG_ACTIVE_LOW, 1, 1: a lit segment/dp is driven 0

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_En  in  1  display enable; 0 blanks the display and holds the scan at digit 0
i_value  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (rightmost)
i_dp  in  NUM_DIGITS  decimal point per digit
i_blank_lz  in  1  leading-zero suppression enable
o_digit  out  NUM_DIGITS  one-hot digit select (polarity per SEL_ACTIVE_LOW)
o_fnd  out  8  {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
o_frame  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Reset (sync, active-high): prescaler=0, idx=0, shadow value/dp=0, o_digit all inactive, o_fnd all off, o_frame=0.
- Prescaler counts 0..DIV_COUNT-1 while i_En=1. tick = (prescaler==DIV_COUNT-1). On tick, prescaler returns to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Counter widths: $clog2 of range, minimum 1 bit.
- Shadow registers: i_value/i_dp load every cycle while i_En=0, and on the wrapping tick while i_En=1. A mid-frame change to i_value is not displayed until the next frame. There is no tearing.
- Outputs are registered, with a latency of 1 cycle from idx/shadow:
  - o_digit = one-hot(idx), inverted if SEL_ACTIVE_LOW.
  - o_fnd = {dp[idx], seg(nibble[idx])}, inverted if SEG_ACTIVE_LOW.
- Each digit is active for exactly DIV_COUNT consecutive cycles. Frame period = NUM_DIGITS*DIV_COUNT cycles.
- o_frame: registered and aligned with the first o_digit cycle of digit 0 after a wrap. It is not asserted on the first frame after reset or enable.
- Segment codes (active-high gfedcba):
  - Digits: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Hex letters: A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Leading-zero suppression (i_blank_lz=1): digit k (k>=1) has its segments blanked when its nibble and all higher nibbles are 0. Digit 0 is never blanked. The dp is still shown.
- i_En=0: on the next cycle, all o_digit lines go inactive and o_fnd is off; prescaler and idx are forced to 0. On re-enable, digit 0 is shown on the following cycle with the shadow captured on the last disabled cycle.
- i_reset has priority over i_En. Reset mid-frame restarts at digit 0 on the cycle after reset deasserts, provided i_En=1.
- NUM_DIGITS=1: idx is held at 0, and o_frame pulses every DIV_COUNT cycles after the first.

Decomposition:
- Package fnd_pkg holds:
  - SEG_0..SEG_F, SEG_BLANK (7-bit gfedcba constants);
  - function seg_encode(nibble, hex_en).
- Sub-module fnd_seg_decoder: combinational nibble-to-segment decode plus blank input, instantiated once on the selected nibble.

Test Plan:
- Configuration for all scenarios: NUM_DIGITS=4, DIV_COUNT=4, both polarities active-low.
- Reset check: assert i_reset for 3 cycles -> o_digit=4'b1111, o_fnd=8'hFF throughout and on the cycle after release.
- Basic scan: i_En=1, i_value=16'h1234, i_dp=0 -> o_digit sequence 1110, 1101, 1011, 0111, 4 cycles each. o_fnd[6:0] is the inverse of 1100110, 1001111, 1011011, 0000110. o_frame pulses with the second 1110 window (cycle 17 after release).
- Tearing check: change i_value to 16'h9999 while digit 1 is lit -> digits 2 and 3 still show 2 and 1; all digits show 9 from the next frame.
- Leading-zero blanking and hex: i_value=16'h0050, i_blank_lz=1, i_dp=4'b0100 -> digits 3 and 2 have segments off, digit 2 dp lit (o_fnd=8'h7F), digit 1='5', digit 0='0'. Then i_value=16'h00AF with HEX_EN=1 -> 'F', 'A'.
- Enable gating: drop i_En mid-digit 2 -> next cycle o_digit=1111 and o_fnd=FF. Re-enable -> digit 0 lit the next cycle for a full 4 cycles.
- Parameter sweep: NUM_DIGITS=1, DIV_COUNT=1 and NUM_DIGITS=8, DIV_COUNT=3, with both polarities -> one-hot/inversion correct, and frame period equals NUM_DIGITS*DIV_COUNT cycles.
